// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Time-multiplexed N-digit seven-segment display driver. A packed word of hex
// nibbles, together with decimal-point, blanking and leading-zero-blank
// controls, is captured into shadow registers only at the end of a full scan,
// so a frame never shows a mix of old and new values. One digit is driven per
// slot of CLK_DIV clocks. Within a slot the anode is PWM-gated for brightness,
// while the segment pattern is held for the whole slot.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   digits_in    packed hex nibbles, digit i = [4i+3:4i], digit 0 rightmost
//   dp_in        decimal point request per digit
//   blank_in     per-digit force-dark (segments, dp and anode)
//   lz_blank_en  suppress leading zeros (digit 0 is always shown)
//   brightness   PWM level, used live rather than shadowed
//   load         request capture of the display inputs at the next frame end
//   seg_out      {dp,g,f,e,d,c,b,a}, registered
//   an_out       one-hot digit enable, registered
//   frame_done   one-cycle pulse after the last slot of each scan
// ---------------------------------------------------------------------------
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 1000,
  parameter int BRIGHT_W       = 4,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_blank_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SLOT_MAX  = SW'(NUM_DIGITS - 1);

  // "Off" levels as seen on the pins, for either polarity.
  localparam logic [7:0]            SEG_OFF = {8{ACTIVE_LOW_SEG != 0}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW_AN != 0}};

  // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h18;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // On-time within a slot. Clamped to at least one clock so the lowest
  // brightness setting is dim rather than fully dark.
  function automatic logic [31:0] pwm_duty(input logic [BRIGHT_W-1:0] lvl);
    logic [31:0] d;
    d = ((32'(lvl) + 32'd1) * 32'(CLK_DIV)) >> BRIGHT_W;
    if (d == 32'd0) d = 32'd1;
    return d;
  endfunction

  // Scan counters
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          eof;

  // Shadowed display state
  logic          load_pend_q, load_pend_d;
  logic [DW-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d;
  logic          sh_lz_q, sh_lz_d;

  // Output registers
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  // Per-slot decode scratch
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_lz;
  logic                  cur_lit;
  logic [7:0]            seg_al;
  logic [NUM_DIGITS-1:0] an_onehot;

  always_comb begin
    // Scan counters
    presc_d = presc_q + PW'(1);
    slot_d  = slot_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      slot_d  = (slot_q == SLOT_MAX) ? '0 : slot_q + SW'(1);
    end
    eof          = (presc_q == PRESC_MAX) && (slot_q == SLOT_MAX);
    frame_done_d = eof;

    // Load handshake: capture happens only at frame end. A load arriving in
    // the EOF cycle itself is honoured immediately.
    load_pend_d = load_pend_q | load;
    sh_digits_d = sh_digits_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    sh_lz_d     = sh_lz_q;
    if (eof && (load_pend_q || load)) begin
      sh_digits_d = digits_in;
      sh_dp_d     = dp_in;
      sh_blank_d  = blank_in;
      sh_lz_d     = lz_blank_en;
      load_pend_d = 1'b0;
    end

    // Decode the digit of the current slot
    cur_nib   = sh_digits_q[{slot_q, 2'b00} +: 4];
    cur_dp    = sh_dp_q[slot_q];
    cur_blank = sh_blank_q[slot_q];
    // Leading zero when this nibble and every more-significant one are zero.
    cur_lz    = sh_lz_q && (slot_q != '0) &&
                ((sh_digits_q >> {slot_q, 2'b00}) == '0);

    if (cur_blank) begin
      seg_al = 8'hFF;
    end else begin
      seg_al = {~cur_dp, (cur_lz ? 7'h7F : hex_glyph(cur_nib))};
    end

    // A suppressed leading zero keeps its anode only to show a lit dp.
    cur_lit   = !cur_blank && (!cur_lz || cur_dp) &&
                (32'(presc_q) < pwm_duty(brightness));
    an_onehot = NUM_DIGITS'(1) << slot_q;

    seg_d = (ACTIVE_LOW_SEG != 0) ? seg_al : ~seg_al;
    if (cur_lit) begin
      an_d = (ACTIVE_LOW_AN != 0) ? ~an_onehot : an_onehot;
    end else begin
      an_d = AN_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      slot_q       <= '0;
      load_pend_q  <= 1'b0;
      sh_digits_q  <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '1;
      sh_lz_q      <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      slot_q       <= slot_d;
      load_pend_q  <= load_pend_d;
      sh_digits_q  <= sh_digits_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      sh_lz_q      <= sh_lz_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//
// Bench for seven_seg_scan_driver with NUM_DIGITS=4, CLK_DIV=4, BRIGHT_W=2,
// active-low pins. A behavioural model follows the display at the level of
// "cycle number within a frame" and the shadowed display values; scenario
// tasks also compare against hand-derived glyph tables.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int CD = 4;
  localparam int BW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lz_blank_en = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic        load = 1'b0;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int compared   = 0;
  int mismatched = 0;

  seven_seg_scan_driver #(
    .NUM_DIGITS(ND), .CLK_DIV(CD), .BRIGHT_W(BW),
    .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)
  ) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_blank_en(lz_blank_en), .brightness(brightness),
    .load(load), .seg_out(seg_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          m_cyc;        // clock index within the current frame, 0..15
  bit          m_pend;
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  bit          m_lz;
  int          m_p, m_s, m_nib, m_duty;
  bit          m_lzs, m_lit;
  logic [7:0]  exp_seg = 8'hFF;
  logic [3:0]  exp_an = 4'hF;
  logic        exp_fd = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cyc = 0; m_pend = 0; m_digits = '0; m_dp = '0; m_blank = 4'hF; m_lz = 0;
      exp_seg = 8'hFF; exp_an = 4'hF; exp_fd = 1'b0;
    end else begin
      m_p   = m_cyc % CD;
      m_s   = m_cyc / CD;
      m_nib = int'((m_digits >> (4 * m_s)) & 16'hF);
      // Leading zero: the number held in digits s..3 is zero, i.e. value < 16^s.
      m_lzs = m_lz && (m_s > 0) && (int'(m_digits) < (1 << (4 * m_s)));
      m_duty = ((int'(brightness) + 1) * CD) / (1 << BW);
      if (m_duty < 1) m_duty = 1;
      if (m_blank[m_s]) exp_seg = 8'hFF;
      else exp_seg = {~m_dp[m_s], (m_lzs ? 7'h7F : glyph_tab[m_nib])};
      m_lit  = !m_blank[m_s] && (!m_lzs || m_dp[m_s]) && (m_p < m_duty);
      exp_an = m_lit ? ~(4'b0001 << m_s) : 4'hF;
      exp_fd = (m_cyc == CD * ND - 1);
      if (exp_fd && (m_pend || load)) begin
        m_digits = digits_in; m_dp = dp_in; m_blank = blank_in; m_lz = lz_blank_en;
        m_pend = 0;
      end else begin
        m_pend = m_pend | load;
      end
      m_cyc = (m_cyc + 1) % (CD * ND);
    end
  end

  // ---------------- helpers (no checking) ----------------
  task automatic wait_fd(output bit ok);
    ok = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; load = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (seg_out !== 8'hFF || an_out !== 4'hF || frame_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: seg=%h an=%h fd=%b, expected seg=ff an=f fd=0",
               seg_out, an_out, frame_done);
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      compared++;
      if (seg_out !== 8'hFF || an_out !== 4'hF) begin
        mismatched++;
        $display("FAIL reset_idle_dark cyc%0d: seg=%h an=%h, expected seg=ff an=f",
                 i, seg_out, an_out);
      end
      compared++;
      if (frame_done !== exp_fd) begin
        mismatched++;
        $display("FAIL reset_idle_fd cyc%0d: fd=%b, expected %b", i, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_digits_1234();
    logic [7:0] tab [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [3:0] a;
    bit ok;
    digits_in = 16'h1234; dp_in = '0; blank_in = '0; lz_blank_en = 1'b0; brightness = 2'd3;
    pulse_load();
    wait_fd(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL digits_1234_fd_timeout: no frame_done within 64 cycles, expected one");
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      a = ~(4'b0001 << (k / 4));
      compared++;
      if (seg_out !== tab[k / 4] || an_out !== a) begin
        mismatched++;
        $display("FAIL digits_1234 k=%0d: seg=%h an=%b, expected seg=%h an=%b",
                 k, seg_out, an_out, tab[k / 4], a);
      end
      compared++;
      if (frame_done !== (k == 15)) begin
        mismatched++;
        $display("FAIL digits_1234_fd k=%0d: fd=%b, expected %b", k, frame_done, k == 15);
      end
    end
  endtask

  task automatic test_lz_dp();
    logic [7:0] stab [4] = '{8'hC0, 8'h88, 8'h7F, 8'hFF};
    logic [3:0] atab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    bit ok;
    digits_in = 16'h00A0; dp_in = 4'b0100; blank_in = '0; lz_blank_en = 1'b1; brightness = 2'd3;
    pulse_load();
    wait_fd(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL lz_dp_fd_timeout: no frame_done within 64 cycles, expected one");
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      compared++;
      if (seg_out !== stab[k / 4] || an_out !== atab[k / 4]) begin
        mismatched++;
        $display("FAIL lz_dp k=%0d: seg=%h an=%b, expected seg=%h an=%b",
                 k, seg_out, an_out, stab[k / 4], atab[k / 4]);
      end
    end
  endtask

  task automatic test_pwm();
    logic [3:0] a;
    bit ok;
    digits_in = 16'h8888; dp_in = '0; blank_in = '0; lz_blank_en = 1'b0; brightness = 2'd1;
    pulse_load();
    wait_fd(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL pwm_fd_timeout: no frame_done within 64 cycles, expected one");
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      // First frame brightness 1 (on 2 of 4), second frame brightness 0 (on 1 of 4).
      if (k < 16) a = ((k % 4) < 2) ? ~(4'b0001 << ((k % 16) / 4)) : 4'hF;
      else        a = ((k % 4) < 1) ? ~(4'b0001 << ((k % 16) / 4)) : 4'hF;
      compared++;
      if (seg_out !== 8'h80 || an_out !== a) begin
        mismatched++;
        $display("FAIL pwm k=%0d: seg=%h an=%b, expected seg=80 an=%b", k, seg_out, an_out, a);
      end
      if (k == 15) brightness = 2'd0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] beef [4] = '{8'h8E, 8'h86, 8'h86, 8'h83};
    logic [7:0] s;
    logic [3:0] a;
    bit ok;
    brightness = 2'd3;
    wait_fd(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL b2b_fd_timeout: no frame_done within 64 cycles, expected one");
    end
    // Current frame still shows 8888 while two loads arrive mid-frame.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      a = ~(4'b0001 << (k / 4));
      compared++;
      if (seg_out !== 8'h80 || an_out !== a) begin
        mismatched++;
        $display("FAIL b2b_no_tear k=%0d: seg=%h an=%b, expected seg=80 an=%b",
                 k, seg_out, an_out, a);
      end
      if (k == 2) begin digits_in = 16'hFFFF; load = 1'b1; end
      if (k == 3) load = 1'b0;
      if (k == 6) begin digits_in = 16'hBEEF; load = 1'b1; end
      if (k == 7) load = 1'b0;
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      a = ~(4'b0001 << (k / 4));
      compared++;
      if (seg_out !== beef[k / 4] || an_out !== a) begin
        mismatched++;
        $display("FAIL b2b_last_wins k=%0d: seg=%h an=%b, expected seg=%h an=%b",
                 k, seg_out, an_out, beef[k / 4], a);
      end
    end
    blank_in = 4'b0010;
    pulse_load();
    wait_fd(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL blank_fd_timeout: no frame_done within 64 cycles, expected one");
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      s = (k / 4 == 1) ? 8'hFF : beef[k / 4];
      a = (k / 4 == 1) ? 4'hF : ~(4'b0001 << (k / 4));
      compared++;
      if (seg_out !== s || an_out !== a) begin
        mismatched++;
        $display("FAIL blank_digit k=%0d: seg=%h an=%b, expected seg=%h an=%b",
                 k, seg_out, an_out, s, a);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Right after a frame boundary: queue a visible load, then reset mid-slot.
    digits_in = 16'h1234; dp_in = 4'hF; blank_in = '0;
    pulse_load();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (seg_out !== 8'hFF || an_out !== 4'hF || frame_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid: seg=%h an=%b fd=%b, expected seg=ff an=1111 fd=0",
               seg_out, an_out, frame_done);
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      compared++;
      if (seg_out !== 8'hFF || an_out !== 4'hF) begin
        mismatched++;
        $display("FAIL reset_mid_dark cyc%0d: seg=%h an=%b, expected seg=ff an=1111",
                 i, seg_out, an_out);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      compared++;
      if (seg_out !== exp_seg || an_out !== exp_an || frame_done !== exp_fd) begin
        mismatched++;
        $display("FAIL random cyc%0d: seg=%h an=%b fd=%b, expected seg=%h an=%b fd=%b",
                 i, seg_out, an_out, frame_done, exp_seg, exp_an, exp_fd);
      end
      digits_in   = 16'($urandom);
      dp_in       = 4'($urandom);
      blank_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      lz_blank_en = 1'($urandom);
      brightness  = 2'($urandom);
      load        = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_digits_1234();
    test_lz_dp();
    test_pwm();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
